// File: rtl/ycr_reset_seq_cell.sv
// N-channel ordered reset sequencer: synchronises per-channel requests and releases channels in index order.
// Optional sticky re-assertion cause flags are enabled with `define YCR_RST_SEQ_CAUSE_EN.
module ycr_reset_seq_cell #(
    parameter int unsigned N_CH        = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            test_mode,
    input  logic            test_rst_n,
    input  logic [N_CH-1:0] rst_req_n_in,
    output logic [N_CH-1:0] rst_n_out,
    output logic [N_CH-1:0] rst_n_status,
    output logic            seq_busy,
    input  logic            cause_clr,
    output logic [N_CH-1:0] cause_o
);

    localparam int unsigned IDX_W = $clog2(N_CH + 1);
    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  req_ok;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]  out_ff_q, out_ff_d;
    logic             busy_q, busy_d;
    logic             reassert_hit;
    logic [IDX_W-1:0] reassert_idx;
    logic             cur_ok;

    // Request synchroniser; reset value means "request asserted".
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= rst_req_n_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign req_ok = sync_q[SYNC_STAGES-1];

    // Sequencer next state: re-assertion of a released channel beats any release.
    always_comb begin
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        reassert_hit = 1'b0;
        reassert_idx = '0;
        cur_ok       = 1'b0;

        for (int k = 0; k < int'(N_CH); k++) begin
            if (!reassert_hit && (IDX_W'(k) < idx_q) && !req_ok[k]) begin
                reassert_hit = 1'b1;
                reassert_idx = IDX_W'(k);
            end
            if (IDX_W'(k) == idx_q) begin
                cur_ok = req_ok[k];
            end
        end

        if (reassert_hit) begin
            idx_d = reassert_idx;
            cnt_d = '0;
        end else if (idx_q < IDX_W'(N_CH)) begin
            if (cur_ok) begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    idx_d = idx_q + IDX_W'(1);
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end

        for (int j = 0; j < int'(N_CH); j++) begin
            out_ff_d[j] = (IDX_W'(j) < idx_d);
        end
        busy_d = (idx_d < IDX_W'(N_CH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            cnt_q    <= '0;
            out_ff_q <= '0;
            busy_q   <= 1'b1;
        end else begin
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            out_ff_q <= out_ff_d;
            busy_q   <= busy_d;
        end
    end

    assign rst_n_status = out_ff_q;
    assign seq_busy     = busy_q;
    assign rst_n_out    = test_mode ? {N_CH{test_rst_n}} : out_ff_q;

`ifdef YCR_RST_SEQ_CAUSE_EN
    logic [N_CH-1:0] cause_set, cause_q, cause_d;

    // Flag every already-released channel seen re-requested; a set beats a clear.
    always_comb begin
        cause_set = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            cause_set[k] = (IDX_W'(k) < idx_q) && !req_ok[k];
        end
        cause_d = cause_q | cause_set;
        if (cause_clr) begin
            cause_d = cause_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q <= '0;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign cause_o = cause_q;
`else
    logic unused_cause_clr;
    assign unused_cause_clr = cause_clr;
    assign cause_o          = '0;
`endif

endmodule
